// File: rtl/xing_ctrl.sv
// xing_ctrl: NS/EW intersection phase controller with a pedestrian WALK phase,
// programmable phase durations and a freeze (hold) input.
`timescale 1ns/1ps
module xing_ctrl #(
  parameter int unsigned T_WIDTH   = 8,
  parameter int unsigned NS_TIME   = 8,
  parameter int unsigned EW_TIME   = 5,
  parameter int unsigned Y_TIME    = 2,
  parameter int unsigned WALK_TIME = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ped_req,
  input  logic               i_hold,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_sel,
  input  logic [T_WIDTH-1:0] i_cfg_data,
  output logic [2:0]         o_state,
  output logic               o_walk,
  output logic               o_ped_ack,
  output logic [T_WIDTH-1:0] o_remaining
);

  typedef enum logic [2:0] {
    ST_START = 3'b111,
    ST_NS    = 3'b011,
    ST_NY    = 3'b010,
    ST_EW    = 3'b000,
    ST_EY    = 3'b001,
    ST_WALK  = 3'b101
  } state_t;

  state_t             r_state;
  logic [T_WIDTH-1:0] r_timer;
  logic               r_pending;
  logic               r_ped_ack;
  logic               r_walk;
  logic [T_WIDTH-1:0] r_dur_ns;
  logic [T_WIDTH-1:0] r_dur_ew;
  logic [T_WIDTH-1:0] r_dur_y;
  logic [T_WIDTH-1:0] r_dur_walk;

  state_t             w_next_state;
  logic [T_WIDTH-1:0] w_next_load;
  logic               w_expire;
  logic               w_enter_walk;

  assign w_expire     = (r_timer == '0) && !i_hold;
  assign w_enter_walk = w_expire && (w_next_state == ST_WALK);

  // Successor phase and the duration it loads; the load sees pre-write register values.
  always_comb begin
    w_next_state = ST_START;
    w_next_load  = r_dur_y;
    case (r_state)
      ST_START: begin
        w_next_state = ST_NS;
        w_next_load  = r_dur_ns;
      end
      ST_NS: begin
        w_next_state = ST_NY;
        w_next_load  = r_dur_y;
      end
      ST_NY: begin
        w_next_state = ST_EW;
        w_next_load  = r_dur_ew;
      end
      ST_EW: begin
        w_next_state = ST_EY;
        w_next_load  = r_dur_y;
      end
      ST_EY: begin
        if (r_pending || i_ped_req) begin
          w_next_state = ST_WALK;
          w_next_load  = r_dur_walk;
        end else begin
          w_next_state = ST_NS;
          w_next_load  = r_dur_ns;
        end
      end
      ST_WALK: begin
        w_next_state = ST_NS;
        w_next_load  = r_dur_ns;
      end
      default: begin
        w_next_state = ST_START;
        w_next_load  = r_dur_y;
      end
    endcase
  end

  // Phase FSM, countdown timer, pedestrian flag/ack and duration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_START;
      r_timer    <= T_WIDTH'(Y_TIME);
      r_pending  <= 1'b0;
      r_ped_ack  <= 1'b0;
      r_walk     <= 1'b0;
      r_dur_ns   <= T_WIDTH'(NS_TIME);
      r_dur_ew   <= T_WIDTH'(EW_TIME);
      r_dur_y    <= T_WIDTH'(Y_TIME);
      r_dur_walk <= T_WIDTH'(WALK_TIME);
    end else begin
      if (i_cfg_we) begin
        case (i_cfg_sel)
          2'd0:    r_dur_ns   <= i_cfg_data;
          2'd1:    r_dur_ew   <= i_cfg_data;
          2'd2:    r_dur_y    <= i_cfg_data;
          default: r_dur_walk <= i_cfg_data;
        endcase
      end

      if (w_expire) begin
        r_state <= w_next_state;
        r_timer <= w_next_load;
        r_walk  <= (w_next_state == ST_WALK);
      end else if (!i_hold) begin
        r_timer <= r_timer - T_WIDTH'(1);
      end

      // Entering WALK consumes both the stored and the coincident request.
      r_pending <= w_enter_walk ? 1'b0 : (r_pending | i_ped_req);
      r_ped_ack <= w_enter_walk;
    end
  end

  assign o_state     = r_state;
  assign o_walk      = r_walk;
  assign o_ped_ack   = r_ped_ack;
  assign o_remaining = r_timer;

endmodule
